instr_sequencer: RTL and testbench
==================================

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64: consecutive FETCH cycles without imem_ready before error (used only under SEQ_TIMEOUT_EN).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  start request; honoured only in IDLE, HALT or ERR.
REQ-005 SHALL have port pc_init  input  32  start address, sampled on an honoured start.
REQ-006 SHALL have port imem_req  output  1  instruction-memory read request.
REQ-007 SHALL have port imem_addr  output  32  fetch address; equals pc.
REQ-008 SHALL have port imem_ready  input  1  memory has returned imem_rdata this cycle.
REQ-009 SHALL have port imem_rdata  input  32  fetched instruction word.
REQ-010 SHALL have port instr  output  32  instruction register; drives the core's instruction input.
REQ-011 SHALL have port wb_en  output  1  one-cycle register-file write qualifier for the core.
REQ-012 SHALL have port pc  output  32  current program counter.
REQ-013 SHALL have port retired  output  16  count of retired instructions.
REQ-014 SHALL have ports busy, halted, err  output  1 each  status flags.

Function
REQ-015 SHALL implement states IDLE, FETCH, EXEC, WB, HALT, ERR, registered on clk.
REQ-016 IDLE: on start=1, pc <= {pc_init[31:2],2'b00}, retired <= 0, next FETCH; otherwise stay.
REQ-017 FETCH: imem_req=1, imem_addr=pc, both held stable until imem_ready sampled 1.
REQ-018 FETCH with imem_ready=1: instr <= imem_rdata, next EXEC (zero-wait fetch costs exactly one cycle).
REQ-019 imem_ready SHALL be ignored in all states other than FETCH.
REQ-020 EXEC: one cycle for the datapath to settle; if instr==32'h0000_0000 next HALT, else next WB.
REQ-021 WB: wb_en=1 for exactly this cycle; pc <= pc+4 (mod 2^32 wrap); retired <= retired+1, saturating at 16'hFFFF; next FETCH.
REQ-022 wb_en SHALL be 0 in every state except WB; a halting (all-zero) instruction SHALL NOT assert wb_en, advance pc, or increment retired.
REQ-023 Throughput with zero-wait memory SHALL be one instruction per 3 cycles (FETCH, EXEC, WB).
REQ-024 HALT: halted=1; on start=1 behave as REQ-016 (clear halted, reload pc, clear retired), next FETCH.
REQ-025 start SHALL be ignored in FETCH, EXEC and WB.
REQ-026 busy SHALL be 1 exactly in FETCH, EXEC and WB.
REQ-027 instr SHALL hold its value outside FETCH-with-ready captures.

Reset
REQ-028 reset=1 SHALL immediately, independent of clk, force state IDLE, pc=0, instr=0, retired=0, imem_req=0, wb_en=0, busy=0, halted=0, err=0, timeout counter=0.
REQ-029 reset asserted mid-fetch or mid-WB SHALL abort the operation with no wb_en pulse after reset takes effect.

Configuration
REQ-030 Macro SEQ_TIMEOUT_EN defined: counter increments each FETCH cycle with imem_ready=0, clears on leaving FETCH; on reaching TIMEOUT_CYCLES, next ERR.
REQ-031 ERR (SEQ_TIMEOUT_EN only): err=1, imem_req=0, pc held; start behaves as REQ-016 and clears err.
REQ-032 SEQ_TIMEOUT_EN undefined: no counter or ERR state logic; FETCH waits indefinitely; err tied 0; port list unchanged.

Verification
REQ-033 reset, pc_init=0x100, start pulse, imem_ready=1 always, rdata=0x00A00093 -> wb_en at cycles 3,6,9 after start; pc 0x104, 0x108, 0x10C; retired 1,2,3.
REQ-034 In FETCH, imem_ready low 5 cycles then high -> imem_req and imem_addr stable all 6 cycles; instr captured on 6th; single wb_en two cycles later.
REQ-035 rdata=0x00000000 on third fetch -> HALT, halted=1, retired=2, no third wb_en; start with pc_init=0x40 -> fetch from 0x40, retired=0.
REQ-036 pc_init=0xFFFF_FFFC, one nonzero instruction -> pc wraps to 0x0000_0000; retired preset 0xFFFF saturates (no wrap to 0).
REQ-037 reset asserted asynchronously mid-WB -> all outputs at reset values before next clk edge; start pulse in EXEC ignored.
REQ-038 SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=8, imem_ready held 0 -> ERR after 8 FETCH cycles, err=1, imem_req=0; without macro -> FETCH held indefinitely, err=0.

Source files
------------

// File: rtl/instr_sequencer.sv
// Fetch/exec/writeback sequencer that drives a single-issue core from an instruction memory.
// Optional fetch timeout with an ERR state is enabled by defining SEQ_TIMEOUT_EN.
module instr_sequencer #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] pc_init,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        wb_en,
    output logic [31:0] pc,
    output logic [15:0] retired,
    output logic        busy,
    output logic        halted,
    output logic        err,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC  = 3'd2,
        S_WB    = 3'd3,
        S_HALT  = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [15:0] r_retired;
    logic        r_imem_req;
    logic        r_wb_en;
    logic        r_busy;
    logic        r_halted;
    logic        w_unused;

`ifdef SEQ_TIMEOUT_EN
    logic        r_err;
    logic [31:0] r_to_cnt;
`endif

    // Memory handshake: imem_req is the valid, imem_ready the response strobe.
    // imem_req/imem_addr stay stable in FETCH until imem_ready is sampled high;
    // imem_ready in any other state is ignored.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_pc       <= 32'h0;
            r_instr    <= 32'h0;
            r_retired  <= 16'h0;
            r_imem_req <= 1'b0;
            r_wb_en    <= 1'b0;
            r_busy     <= 1'b0;
            r_halted   <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
            r_err      <= 1'b0;
            r_to_cnt   <= 32'h0;
`endif
        end else begin
            r_wb_en <= 1'b0;
            case (r_state)
`ifdef SEQ_TIMEOUT_EN
                S_IDLE, S_HALT, S_ERR: begin
`else
                S_IDLE, S_HALT: begin
`endif
                    if (start) begin
                        r_pc       <= {pc_init[31:2], 2'b00};
                        r_retired  <= 16'h0;
                        r_state    <= S_FETCH;
                        r_imem_req <= 1'b1;
                        r_busy     <= 1'b1;
                        r_halted   <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
                        r_err      <= 1'b0;
`endif
                    end
                end
                S_FETCH: begin
                    if (imem_ready) begin
                        r_instr    <= imem_rdata;
                        r_state    <= S_EXEC;
                        r_imem_req <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
                        r_to_cnt   <= 32'h0;
`endif
                    end
`ifdef SEQ_TIMEOUT_EN
                    else if (r_to_cnt == 32'(TIMEOUT_CYCLES - 1)) begin
                        // This is the TIMEOUT_CYCLES-th consecutive cycle without a response.
                        r_state    <= S_ERR;
                        r_imem_req <= 1'b0;
                        r_busy     <= 1'b0;
                        r_err      <= 1'b1;
                        r_to_cnt   <= 32'h0;
                    end else begin
                        r_to_cnt   <= r_to_cnt + 32'd1;
                    end
`endif
                end
                S_EXEC: begin
                    // An all-zero word halts without touching pc, retired or wb_en.
                    if (r_instr == 32'h0) begin
                        r_state  <= S_HALT;
                        r_busy   <= 1'b0;
                        r_halted <= 1'b1;
                    end else begin
                        r_state  <= S_WB;
                        r_wb_en  <= 1'b1;
                    end
                end
                S_WB: begin
                    r_pc       <= r_pc + 32'd4;
                    if (r_retired != 16'hFFFF) begin
                        r_retired <= r_retired + 16'd1;
                    end
                    r_state    <= S_FETCH;
                    r_imem_req <= 1'b1;
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_imem_req <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req  = r_imem_req;
    assign imem_addr = r_pc;
    assign instr     = r_instr;
    assign wb_en     = r_wb_en;
    assign pc        = r_pc;
    assign retired   = r_retired;
    assign busy      = r_busy;
    assign halted    = r_halted;
    assign dbg_state = r_state;

`ifdef SEQ_TIMEOUT_EN
    assign err = r_err;
`else
    assign err = 1'b0;
`endif

    // Word alignment drops pc_init[1:0]; the timeout depth only matters with the timeout built in.
    assign w_unused = ^{pc_init[1:0], (TIMEOUT_CYCLES > 0)};

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: memory responder plus wb scoreboard, directed scenarios.
module tb_instr_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [31:0] pc_init = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] instr;
  logic        wb_en;
  logic [31:0] pc;
  logic [15:0] retired;
  logic        busy;
  logic        halted;
  logic        err;
  logic [2:0]  dbg_state;

  instr_sequencer #(.TIMEOUT_CYCLES(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .pc_init    (pc_init),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .instr      (instr),
    .wb_en      (wb_en),
    .pc         (pc),
    .retired    (retired),
    .busy       (busy),
    .halted     (halted),
    .err        (err),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];
  logic [31:0] prog_q[$];
  logic [31:0] model_pc = 32'h0;
  int wait_cfg = 0;
  int low_cnt = 0;
  bit ready_always = 1'b0;
  int wb_count = 0;
  int wb_base = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h @%0t", tag, act, exp, $time);
    end
  endtask

  // One cycle: advance to negedge, score any writeback, then play the memory.
  task automatic tick();
    logic [63:0] e;
    logic [31:0] word;
    @(negedge clk);
    if (wb_en === 1'b1) begin
      wb_count++;
      check("wb_expected", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("wb_pc", 64'(pc), 64'(e[63:32]));
        check("wb_instr", 64'(instr), 64'(e[31:0]));
      end
    end
    if (reset) begin
      imem_ready = 1'b0;
      low_cnt = 0;
    end else if (imem_req) begin
      if (low_cnt < wait_cfg) begin
        imem_ready = 1'b0;
        low_cnt++;
      end else begin
        word = 32'h0;
        if (prog_q.size() > 0) word = prog_q.pop_front();
        check("fetch_addr", 64'(imem_addr), 64'(model_pc));
        imem_ready = 1'b1;
        imem_rdata = word;
        low_cnt = 0;
        if (word != 32'h0) begin
          exp_q.push_back({model_pc, word});
          model_pc = model_pc + 32'd4;
        end
      end
    end else begin
      imem_ready = ready_always;
      low_cnt = 0;
    end
  endtask

  // Called at a negedge; after it returns the next tick() lands in cycle 1 (FETCH).
  task automatic do_start(input logic [31:0] addr);
    start = 1'b1;
    pc_init = addr;
    model_pc = {addr[31:2], 2'b00};
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_halt(input string tag);
    for (int i = 0; i < 300 && halted !== 1'b1; i++) tick();
    check(tag, 64'(halted), 64'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_pc"}, 64'(pc), 64'd0);
    check({tag, "_instr"}, 64'(instr), 64'd0);
    check({tag, "_retired"}, 64'(retired), 64'd0);
    check({tag, "_imem_req"}, 64'(imem_req), 64'd0);
    check({tag, "_imem_addr"}, 64'(imem_addr), 64'd0);
    check({tag, "_wb_en"}, 64'(wb_en), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_halted"}, 64'(halted), 64'd0);
    check({tag, "_err"}, 64'(err), 64'd0);
  endtask

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog act=running exp=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset takes effect without a clock edge.
    #1 reset = 1'b1;
    #1 check_reset_vals("rst");
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Zero-wait stream: wb_en every third cycle, start in EXEC ignored.
    ready_always = 1'b1;
    for (int i = 0; i < 3; i++) prog_q.push_back(32'h00A0_0093);
    wb_base = wb_count;
    do_start(32'h0000_0100);
    for (int i = 1; i <= 10; i++) begin
      tick();
      check("t1_wb_en", 64'(wb_en), 64'((i % 3) == 0));
      check("t1_busy", 64'(busy), 64'd1);
      if (i % 3 == 1 && i > 1) begin
        check("t1_pc", 64'(pc), 64'(32'h100 + 32'(4 * ((i - 1) / 3))));
        check("t1_retired", 64'(retired), 64'((i - 1) / 3));
      end
      if (i == 2) begin
        start = 1'b1;
        pc_init = 32'h0000_0500;
      end
      if (i == 3) start = 1'b0;
    end
    wait_halt("t1_halt");
    check("t1_retired_end", 64'(retired), 64'd3);
    check("t1_busy_end", 64'(busy), 64'd0);
    check("t1_wb_total", 64'(wb_count - wb_base), 64'd3);
    ready_always = 1'b0;

    // Wait states: request and address held until the response.
    wait_cfg = 5;
    prog_q.push_back(32'h1111_1111);
    wb_base = wb_count;
    do_start(32'h0000_0200);
    for (int i = 1; i <= 9; i++) begin
      tick();
      if (i <= 6) begin
        check("t2_req", 64'(imem_req), 64'd1);
        check("t2_addr", 64'(imem_addr), 64'h200);
      end
      if (i == 7) check("t2_instr", 64'(instr), 64'h1111_1111);
      check("t2_wb_en", 64'(wb_en), 64'(i == 8));
    end
    wait_halt("t2_halt");
    check("t2_retired", 64'(retired), 64'd1);
    check("t2_wb_total", 64'(wb_count - wb_base), 64'd1);
    wait_cfg = 0;

    // Halt on the third fetch, then restart from an unaligned pc_init.
    prog_q.push_back(32'hDEAD_BEEF);
    prog_q.push_back(32'h0000_0013);
    wb_base = wb_count;
    do_start(32'h0000_0300);
    wait_halt("t3_halt");
    check("t3_retired", 64'(retired), 64'd2);
    check("t3_pc", 64'(pc), 64'h308);
    check("t3_busy", 64'(busy), 64'd0);
    check("t3_wb_total", 64'(wb_count - wb_base), 64'd2);
    prog_q.push_back(32'h0000_0005);
    do_start(32'h0000_0043);
    tick();
    check("t3_restart_addr", 64'(imem_addr), 64'h40);
    check("t3_restart_retired", 64'(retired), 64'd0);
    check("t3_restart_halted", 64'(halted), 64'd0);
    check("t3_restart_busy", 64'(busy), 64'd1);
    wait_halt("t3_halt2");
    check("t3_retired2", 64'(retired), 64'd1);
    check("t3_pc2", 64'(pc), 64'h44);

    // pc wraps at the top of memory; retired saturates.
    wait_cfg = 3;
    prog_q.push_back(32'hCAFE_0001);
    wb_base = wb_count;
    do_start(32'hFFFF_FFFC);
    tick();
    force dut.r_retired = 16'hFFFF;
    #1 release dut.r_retired;
    wait_halt("t4_halt");
    check("t4_pc_wrap", 64'(pc), 64'h0);
    check("t4_retired_sat", 64'(retired), 64'hFFFF);
    check("t4_wb_total", 64'(wb_count - wb_base), 64'd1);
    wait_cfg = 0;

    // Asynchronous reset in WB aborts with no further wb_en.
    prog_q.push_back(32'h0000_0022);
    prog_q.push_back(32'h0000_0033);
    do_start(32'h0000_0700);
    tick();
    tick();
    tick();
    check("t5_in_wb", 64'(wb_en), 64'd1);
    #2 reset = 1'b1;
    #1 check_reset_vals("t5_async");
    prog_q.delete();
    exp_q.delete();
    tick();
    check("t5_rst_wb_en", 64'(wb_en), 64'd0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t5_post_wb_en", 64'(wb_en), 64'd0);
      check("t5_post_req", 64'(imem_req), 64'd0);
      check("t5_post_busy", 64'(busy), 64'd0);
    end

    // Memory never answers.
`ifdef SEQ_TIMEOUT_EN
    wait_cfg = 1000;
    do_start(32'h0000_0600);
    for (int i = 1; i <= 8; i++) begin
      tick();
      check("t6_req", 64'(imem_req), 64'd1);
      check("t6_err_low", 64'(err), 64'd0);
    end
    tick();
    check("t6_err", 64'(err), 64'd1);
    check("t6_err_req", 64'(imem_req), 64'd0);
    check("t6_err_busy", 64'(busy), 64'd0);
    check("t6_err_pc", 64'(pc), 64'h600);
    wait_cfg = 0;
    prog_q.push_back(32'h0000_0077);
    do_start(32'h0000_0800);
    wait_halt("t6_recover_halt");
    check("t6_recover_err", 64'(err), 64'd0);
    check("t6_recover_retired", 64'(retired), 64'd1);
`else
    wait_cfg = 20;
    do_start(32'h0000_0600);
    for (int i = 1; i <= 12; i++) begin
      tick();
      check("t6_req", 64'(imem_req), 64'd1);
      check("t6_addr", 64'(imem_addr), 64'h600);
      check("t6_err", 64'(err), 64'd0);
      check("t6_busy", 64'(busy), 64'd1);
    end
    wait_halt("t6_late_halt");
    check("t6_late_err", 64'(err), 64'd0);
    wait_cfg = 0;
`endif

    check("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
